// File: rtl/lbp_scan_ctrl.sv
// Serpentine LBP scan sequencer: fetches each 3x3 window (9 reads first, then 3 per move) and writes LBP codes.
// Optional: define LBP_SCAN_CHK_EN to build the shadow address/fill checker driving scan_err.

module lbp_scan_ctrl #(
  parameter int IMG_DIM = 128,
  parameter int PIX_W   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             gray_ready,
  output logic             gray_req,
  output logic [13:0]      gray_addr,
  input  logic [PIX_W-1:0] gray_data,
  input  logic [13:0]      lbp_addr,
  input  logic             fill_right,
  input  logic             fill_down,
  input  logic             fill_left,
  output logic             lbp_addr_en,
  output logic             lbp_valid,
  output logic [PIX_W-1:0] lbp_data,
  output logic             finish,
  output logic             scan_err
);

  localparam logic [6:0]  EDGE_COL    = 7'(IMG_DIM - 2);
  localparam logic [13:0] LAST_CENTER = {7'(IMG_DIM - 2), 7'd1};

  typedef enum logic [2:0] {IDLE, FETCH, LAST, CALC, WRITE, DONE} state_t;
  typedef enum logic [1:0] {M_FULL, M_RIGHT, M_LEFT, M_DOWN} mode_t;

  state_t           state, state_nxt;
  mode_t            mode_q, flag_mode, cur_mode;
  logic [3:0]       req_cnt;
  logic             partial, last_ctr, first, req_last;
  logic [6:0]       ctr_row, ctr_col, cur_row, cur_col, rd_row, rd_col;
  logic [1:0]       dr, dc, cap_dr, cap_dc;
  logic             cap_vld;
  logic [PIX_W-1:0] w [3][3];
  logic [PIX_W-1:0] code;

  // The center and fetch pattern are taken live on the first FETCH cycle, then held.
  always_comb begin
    first = (state == FETCH) && (req_cnt == 4'd0);
    if (fill_right)     flag_mode = M_RIGHT;
    else if (fill_left) flag_mode = M_LEFT;
    else if (fill_down) flag_mode = M_DOWN;
    else                flag_mode = M_FULL;
    cur_mode = mode_q;
    cur_row  = ctr_row;
    cur_col  = ctr_col;
    if (first) begin
      cur_mode = partial ? flag_mode : M_FULL;
      cur_row  = lbp_addr[13:7];
      cur_col  = lbp_addr[6:0];
    end
    req_last = (cur_mode == M_FULL) ? (req_cnt == 4'd8) : (req_cnt == 4'd2);
  end

  // (dr,dc) is both the read offset from (r-1,c-1) and the window slot to fill.
  always_comb begin
    dr = 2'd0;
    dc = 2'd0;
    case (cur_mode)
      M_FULL: begin
        if (req_cnt < 4'd3) begin
          dc = req_cnt[1:0];
        end else if (req_cnt < 4'd6) begin
          dr = 2'd1;
          dc = 2'(req_cnt - 4'd3);
        end else begin
          dr = 2'd2;
          dc = 2'(req_cnt - 4'd6);
        end
      end
      M_RIGHT: begin
        dr = req_cnt[1:0];
        dc = 2'd2;
      end
      M_LEFT: begin
        dr = req_cnt[1:0];
      end
      M_DOWN: begin
        dr = 2'd2;
        dc = req_cnt[1:0];
      end
      default: ;
    endcase
    rd_row = cur_row + {5'd0, dr} - 7'd1;
    rd_col = cur_col + {5'd0, dc} - 7'd1;
  end

  always_comb begin
    code = {w[2][2] >= w[1][1], w[2][1] >= w[1][1], w[2][0] >= w[1][1], w[1][2] >= w[1][1],
            w[1][0] >= w[1][1], w[0][2] >= w[1][1], w[0][1] >= w[1][1], w[0][0] >= w[1][1]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    gray_req    = 1'b0;
    gray_addr   = '0;
    lbp_valid   = 1'b0;
    lbp_addr_en = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: if (gray_ready) state_nxt = FETCH;
      FETCH: begin
        gray_req  = 1'b1;
        gray_addr = {rd_row, rd_col};
        if (req_last) state_nxt = LAST;
      end
      LAST: state_nxt = CALC;
      CALC: state_nxt = WRITE;
      WRITE: begin
        lbp_valid   = 1'b1;
        lbp_addr_en = !last_ctr;
        state_nxt   = last_ctr ? DONE : FETCH;
      end
      DONE: finish = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_cnt  <= 4'd0;
      mode_q   <= M_FULL;
      ctr_row  <= 7'd0;
      ctr_col  <= 7'd0;
      partial  <= 1'b0;
      last_ctr <= 1'b0;
      lbp_data <= '0;
      cap_vld  <= 1'b0;
      cap_dr   <= 2'd0;
      cap_dc   <= 2'd0;
    end else begin
      cap_vld <= gray_req;
      cap_dr  <= dr;
      cap_dc  <= dc;
      if (first) begin
        mode_q  <= cur_mode;
        ctr_row <= cur_row;
        ctr_col <= cur_col;
      end
      if (state == FETCH) req_cnt <= req_last ? 4'd0 : req_cnt + 4'd1;
      if (state == CALC) begin
        lbp_data <= code;
        last_ctr <= (lbp_addr == LAST_CENTER);
      end
      if (state == WRITE && !last_ctr) partial <= 1'b1;
    end
  end

  // Shift happens on the first partial cycle; captures land one cycle after each read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w[i][j] <= '0;
    end else begin
      if (first) begin
        case (cur_mode)
          M_RIGHT:
            for (int i = 0; i < 3; i++) begin
              w[i][0] <= w[i][1];
              w[i][1] <= w[i][2];
            end
          M_LEFT:
            for (int i = 0; i < 3; i++) begin
              w[i][2] <= w[i][1];
              w[i][1] <= w[i][0];
            end
          M_DOWN:
            for (int j = 0; j < 3; j++) begin
              w[0][j] <= w[1][j];
              w[1][j] <= w[2][j];
            end
          default: ;
        endcase
      end
      if (cap_vld) w[cap_dr][cap_dc] <= gray_data;
    end
  end

`ifdef LBP_SCAN_CHK_EN
  logic [6:0] sh_row, sh_col;
  mode_t      sh_move;
  logic       err_q, flags_onehot;

  always_comb begin
    flags_onehot = ({fill_right, fill_left, fill_down} == 3'b100) ||
                   ({fill_right, fill_left, fill_down} == 3'b010) ||
                   ({fill_right, fill_left, fill_down} == 3'b001);
  end

  // Shadow generator: odd rows move right, even rows move left, turning down at the edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sh_row  <= 7'd1;
      sh_col  <= 7'd1;
      sh_move <= M_FULL;
      err_q   <= 1'b0;
    end else begin
      if (lbp_addr_en) begin
        if (sh_row[0]) begin
          if (sh_col == EDGE_COL) begin
            sh_row  <= sh_row + 7'd1;
            sh_move <= M_DOWN;
          end else begin
            sh_col  <= sh_col + 7'd1;
            sh_move <= M_RIGHT;
          end
        end else begin
          if (sh_col == 7'd1) begin
            sh_row  <= sh_row + 7'd1;
            sh_move <= M_DOWN;
          end else begin
            sh_col  <= sh_col - 7'd1;
            sh_move <= M_LEFT;
          end
        end
      end
      if (state == CALC && lbp_addr != {sh_row, sh_col}) err_q <= 1'b1;
      if (first && partial && (!flags_onehot || flag_mode != sh_move)) err_q <= 1'b1;
    end
  end

  assign scan_err = err_q;
`else
  assign scan_err = 1'b0;
`endif

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Scoreboard bench for lbp_scan_ctrl with a serpentine generator model and image memory model.

module tb_lbp_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n, gray_ready, gray_req;
  logic        fill_right, fill_down, fill_left;
  logic        lbp_addr_en, lbp_valid, finish, scan_err;
  logic [13:0] gray_addr, lbp_addr;
  logic [7:0]  gray_data, lbp_data;
  logic [6:0]  gen_row, gen_col;
  logic [6:0]  nxt_row, nxt_col;
  int          nxt_mode;
  logic [6:0]  preset_row = 7'd1;
  logic [6:0]  preset_col = 7'd1;
  logic [13:0] last_addr = '0;
  logic [7:0]  last_data = '0;
  int          img_mode = 0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_valid = 0;
  int          first_req_cyc = 0;
  int          last_valid_cyc = 0;
  int          base;

  typedef struct { logic [13:0] addr; bit first; } rd_t;
  typedef struct { logic [13:0] addr; logic [7:0] code; bit full; } out_t;
  rd_t  rd_q[$];
  out_t out_q[$];

  assign lbp_addr = {gen_row, gen_col};

  lbp_scan_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .lbp_addr   (lbp_addr),
    .fill_right (fill_right),
    .fill_down  (fill_down),
    .fill_left  (fill_left),
    .lbp_addr_en(lbp_addr_en),
    .lbp_valid  (lbp_valid),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .scan_err   (scan_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pix(input logic [6:0] r, input logic [6:0] c);
    int ri, ci;
    ri = int'(r);
    ci = int'(c);
    if (img_mode == 1) return 8'h55;
    if (img_mode == 2) return 8'(((ri * 7) ^ (ci * 13)) + ri * ci);
    return 8'(ri + ci);
  endfunction

  function automatic void check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // m: 0 = full window, 1 = right column, 2 = left column, 3 = bottom row.
  function automatic void push_center(input logic [6:0] r, input logic [6:0] c, input int m);
    rd_t        rd;
    out_t       o;
    logic [7:0] ctr;
    logic [6:0] rr, cc;
    int         n;
    n = (m == 0) ? 9 : 3;
    for (int k = 0; k < n; k++) begin
      case (m)
        0:       begin rr = r - 7'd1 + 7'(k / 3); cc = c - 7'd1 + 7'(k % 3); end
        1:       begin rr = r - 7'd1 + 7'(k);     cc = c + 7'd1;             end
        2:       begin rr = r - 7'd1 + 7'(k);     cc = c - 7'd1;             end
        default: begin rr = r + 7'd1;             cc = c - 7'd1 + 7'(k);     end
      endcase
      rd.addr  = {rr, cc};
      rd.first = (m == 0) && (k == 0);
      rd_q.push_back(rd);
    end
    ctr    = pix(r, c);
    o.code = {pix(r + 7'd1, c + 7'd1) >= ctr, pix(r + 7'd1, c) >= ctr, pix(r + 7'd1, c - 7'd1) >= ctr,
              pix(r, c + 7'd1) >= ctr, pix(r, c - 7'd1) >= ctr,
              pix(r - 7'd1, c + 7'd1) >= ctr, pix(r - 7'd1, c) >= ctr, pix(r - 7'd1, c - 7'd1) >= ctr};
    o.addr = {r, c};
    o.full = (m == 0);
    out_q.push_back(o);
  endfunction

  always @(posedge clk) gray_data <= pix(gray_addr[13:7], gray_addr[6:0]);

  // Serpentine generator model; each advance issues the next center to the scoreboard.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gen_row    <= preset_row;
      gen_col    <= preset_col;
      fill_right <= 1'b0;
      fill_left  <= 1'b0;
      fill_down  <= 1'b0;
    end else if (lbp_addr_en) begin
      nxt_row = gen_row;
      nxt_col = gen_col;
      if (gen_row[0]) begin
        if (gen_col == 7'd126) begin nxt_row = gen_row + 7'd1; nxt_mode = 3; end
        else begin nxt_col = gen_col + 7'd1; nxt_mode = 1; end
      end else begin
        if (gen_col == 7'd1) begin nxt_row = gen_row + 7'd1; nxt_mode = 3; end
        else begin nxt_col = gen_col - 7'd1; nxt_mode = 2; end
      end
      gen_row    <= nxt_row;
      gen_col    <= nxt_col;
      fill_right <= (nxt_mode == 1);
      fill_left  <= (nxt_mode == 2);
      fill_down  <= (nxt_mode == 3);
      push_center(nxt_row, nxt_col, nxt_mode);
    end
  end

  // Monitor: pops expected reads and writes whenever the DUT presents them.
  always @(negedge clk) begin
    rd_t  rd;
    out_t o;
    if (reset_n) begin
      if (gray_req) begin
        if (rd_q.size() == 0) begin
          check_output("rd_q_level", rd_q.size(), 1);
        end else begin
          rd = rd_q.pop_front();
          check_output("rd_addr", gray_addr, rd.addr);
          if (rd.first) first_req_cyc = cyc;
        end
      end
      if (lbp_valid) begin
        n_valid++;
        last_addr = lbp_addr;
        last_data = lbp_data;
        if (out_q.size() == 0) begin
          check_output("out_q_level", out_q.size(), 1);
        end else begin
          o = out_q.pop_front();
          check_output("wr_addr", lbp_addr, o.addr);
          check_output("wr_data", lbp_data, o.code);
          check_output("wr_addr_en", lbp_addr_en, o.addr != 14'h3F01);
          if (o.full) check_output("full_latency", cyc - first_req_cyc, 11);
          else        check_output("partial_spacing", cyc - last_valid_cyc, 6);
        end
        last_valid_cyc = cyc;
      end else begin
        check_output("addr_en_alone", lbp_addr_en, 0);
      end
    end
  end

  task automatic apply_stimulus(input string tag);
    push_center(gen_row, gen_col, 0);
    check_output({tag, "_idle_req"}, gray_req, 0);
    gray_ready = 1'b1;
    @(negedge clk);
    check_output({tag, "_first_req"}, gray_req, 1);
    check_output({tag, "_first_addr"}, gray_addr, {gen_row - 7'd1, gen_col - 7'd1});
    gray_ready = 1'b0;
  endtask

  task automatic wait_valid(input int n, input int budget);
    int b;
    b = budget;
    while (n_valid < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    check_output("wait_valid", n_valid, n);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_gray_req"}, gray_req, 0);
    check_output({tag, "_gray_addr"}, gray_addr, 0);
    check_output({tag, "_addr_en"}, lbp_addr_en, 0);
    check_output({tag, "_valid"}, lbp_valid, 0);
    check_output({tag, "_data"}, lbp_data, 0);
    check_output({tag, "_finish"}, finish, 0);
    check_output({tag, "_scan_err"}, scan_err, 0);
  endtask

  initial begin
    int b;
    reset_n    = 1'b0;
    gray_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("idle_wait", gray_req, 0);

    // Ramp image: every center codes to 0xF4 (b2 and b5 tie with the center).
    apply_stimulus("ramp");
    wait_valid(1, 40);
    check_output("first_center", last_addr, 14'h0081);
    check_output("first_code", last_data, 8'hF4);
    wait_valid(199, 1500);

    b = 20;
    while (!gray_req && b > 0) begin
      @(negedge clk);
      b--;
    end
    check_output("center200_fetch", gray_req, 1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midrst");
    rd_q.delete();
    out_q.delete();
    img_mode = 2;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_output("restart_idle", gray_req, 0);
    base = n_valid;
    apply_stimulus("restart");
    wait_valid(base + 130, 1000);

    // Jump the generator near the end on a constant image and run to completion.
    preset_row = 7'd126;
    preset_col = 7'd10;
    @(negedge clk);
    #2 reset_n = 1'b0;
    rd_q.delete();
    out_q.delete();
    img_mode = 1;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    base = n_valid;
    apply_stimulus("tail");
    b = 300;
    while (!finish && b > 0) begin
      @(negedge clk);
      b--;
    end
    check_output("finish_seen", finish, 1);
    check_output("finish_delay", cyc - last_valid_cyc, 1);
    check_output("last_center", last_addr, 14'h3F01);
    check_output("last_code", last_data, 8'hFF);
    check_output("tail_count", n_valid - base, 10);
    repeat (5) @(negedge clk);
    check_output("finish_sticky", finish, 1);
    check_output("done_valid", lbp_valid, 0);
    check_output("done_req", gray_req, 0);
    check_output("done_count", n_valid - base, 10);
    check_output("rd_q_drained", rd_q.size(), 0);
    check_output("out_q_drained", out_q.size(), 0);
`ifdef LBP_SCAN_CHK_EN
    check_output("scan_err_jump", scan_err, 1);
`else
    check_output("scan_err_off", scan_err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
